// File: rtl/vga_pkg.sv
// Shared timing constants, framebuffer geometry and helpers for the VGA pixel sink.
// The scan counters are 10 bits wide, so the timing constants are sized to match them.
package vga_pkg;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int FB_AW    = 15;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pix_wr_t;

  localparam int PIX_WR_W = $bits(pix_wr_t);

  function automatic logic [23:0] expand_colour(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  // row*160 + col, built from shifts so no multiplier is needed.
  function automatic logic [FB_AW-1:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
    return ({8'd0, row} << 7) + ({8'd0, row} << 5) + {7'd0, col};
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous write FIFO; pointers carry one extra wrap bit so full and empty differ.
module pixel_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int WIDTH      = 18
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_push,
  input  logic [WIDTH-1:0]            i_data,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_data,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign o_count = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/vga_pixel_sink.sv
// Buffers 160x120 pixel writes into a single-port framebuffer and scans it out
// as 640x480@60 VGA with 4x replication; scanout reads always win the RAM port.
module vga_pixel_sink
  import vga_pkg::*;
#(
  parameter int X_PIXELS   = 160,
  parameter int Y_PIXELS   = 120,
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_DIV    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       ready,
  output logic       oob_err,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       frame_start
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_hcnt;
  logic [9:0]       r_vcnt;
  logic             w_ptick;
  logic             w_visible;
  logic             w_rd;
  logic             w_pop;
  logic             w_we;
  logic             w_oob;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [PIX_WR_W-1:0] w_fifo_q;
  pix_wr_t          w_head;
  logic [FB_AW-1:0] w_ram_addr;

  logic [2:0]  r_fb [FB_DEPTH];
  logic [2:0]  r_pix;
  logic        r_vis1, r_hs1, r_vs1;
  logic        r_blank_n, r_hsync, r_vsync, r_frame_start, r_oob_err;
  logic [23:0] r_rgb;

  assign w_ptick   = (r_div == '0);
  assign w_visible = (r_hcnt < H_VISIBLE) && (r_vcnt < V_VISIBLE);
  assign w_rd      = w_ptick && w_visible && (r_hcnt[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div  <= '0;
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_div <= (r_div == DIV_W'(PIX_DIV - 1)) ? '0 : r_div + 1'b1;
      if (w_ptick) begin
        if (r_hcnt == H_LAST) begin
          r_hcnt <= '0;
          r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 10'd1;
        end else begin
          r_hcnt <= r_hcnt + 10'd1;
        end
      end
    end
  end

  pixel_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(PIX_WR_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (plot && ready),
    .i_data  ({x, y, colour}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_q),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign ready  = 32'(w_count) < FIFO_DEPTH;
  assign w_head = pix_wr_t'(w_fifo_q);
  assign w_oob  = (32'(w_head.x) >= X_PIXELS) || (32'(w_head.y) >= Y_PIXELS);
  assign w_pop  = !w_rd && !w_empty;
  // Reset gates the write so an entry popping in a reset cycle is dropped.
  assign w_we   = reset && w_pop && !w_oob;

  assign w_ram_addr = w_rd ? fb_addr(r_vcnt[8:2], r_hcnt[9:2]) : fb_addr(w_head.y, w_head.x);

  // r_pix only changes on read slots, so it holds the pixel across its 4 replicas.
  always_ff @(posedge clk) begin
    if (w_we) r_fb[w_ram_addr] <= w_head.colour;
    else if (w_rd) r_pix <= r_fb[w_ram_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_oob_err     <= 1'b0;
      r_frame_start <= 1'b0;
      r_vis1        <= 1'b0;
      r_hs1         <= 1'b1;
      r_vs1         <= 1'b1;
      r_blank_n     <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_rgb         <= '0;
    end else begin
      if (w_pop && w_oob) r_oob_err <= 1'b1;
      r_frame_start <= w_ptick && (r_hcnt == '0) && (r_vcnt == '0);
      if (w_ptick) begin
        r_vis1    <= w_visible;
        r_hs1     <= !((r_hcnt >= H_SYNC_START) && (r_hcnt < H_SYNC_END));
        r_vs1     <= !((r_vcnt >= V_SYNC_START) && (r_vcnt < V_SYNC_END));
        r_blank_n <= r_vis1;
        r_hsync   <= r_hs1;
        r_vsync   <= r_vs1;
        r_rgb     <= r_vis1 ? expand_colour(r_pix) : 24'd0;
      end
    end
  end

  assign oob_err     = r_oob_err;
  assign frame_start = r_frame_start;
  assign blank_n     = r_blank_n;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign {r, g, b}   = r_rgb;

endmodule
